// File: rtl/z80_bus_tracer.sv
// ---------------------------------------------------------------------------
// z80_bus_tracer
//   Passive monitor on the tv80s bus. Each completed bus cycle is classified
//   (fetch, memory rd/wr, IO rd/wr, interrupt acknowledge), packed into one
//   27-bit record {kind[2:0], addr[15:0], data[7:0]} and queued in a FIFO.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   cen                     clock enable; freezes sampling + FSM (pop stays live)
//   trace_en                gates the start of new cycles
//   m1_n..rfsh_n, A, di,    CPU bus strobes, address, read data, write data
//   dout
//   trace_valid/trace_data  FIFO head (data forced to 0 when empty)
//   trace_rdy               pop strobe
//   trace_count             records held
//   overflow, dropped       sticky overflow flag, saturating drop counter
// ---------------------------------------------------------------------------
module z80_bus_tracer #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cen,
    input  logic                     trace_en,
    input  logic                     m1_n,
    input  logic                     mreq_n,
    input  logic                     iorq_n,
    input  logic                     rd_n,
    input  logic                     wr_n,
    input  logic                     rfsh_n,
    input  logic [15:0]              A,
    input  logic [7:0]               di,
    input  logic [7:0]               dout,
    output logic                     trace_valid,
    output logic [26:0]              trace_data,
    input  logic                     trace_rdy,
    output logic [$clog2(DEPTH):0]   trace_count,
    output logic                     overflow,
    output logic [CNT_W-1:0]         dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    localparam logic [2:0] K_FETCH = 3'd0;
    localparam logic [2:0] K_MRD   = 3'd1;
    localparam logic [2:0] K_MWR   = 3'd2;
    localparam logic [2:0] K_IORD  = 3'd3;
    localparam logic [2:0] K_IOWR  = 3'd4;
    localparam logic [2:0] K_INTA  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    // Write cycles carry the CPU's outgoing data; everything else the incoming.
    function automatic logic [7:0] sel_data(input logic [2:0] k,
                                            input logic [7:0] rdat,
                                            input logic [7:0] wdat);
        return (k == K_MWR || k == K_IOWR) ? wdat : rdat;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic q_fetch, q_mrd, q_mwr, q_iord, q_iowr, q_inta;
    logic any_q;
    logic [2:0] new_kind;
    logic kind_hold;

    always_comb begin
        q_fetch = !m1_n && !mreq_n && !rd_n;
        q_mrd   =  m1_n && !mreq_n && !rd_n && rfsh_n;
        q_mwr   = !mreq_n && !wr_n;
        q_iord  = !iorq_n && !rd_n && m1_n;
        q_iowr  = !iorq_n && !wr_n;
        q_inta  = !m1_n && !iorq_n;
    end

    always_comb begin
        any_q    = 1'b1;
        new_kind = K_FETCH;
        if (q_inta)       new_kind = K_INTA;
        else if (q_fetch) new_kind = K_FETCH;
        else if (q_mwr)   new_kind = K_MWR;
        else if (q_mrd)   new_kind = K_MRD;
        else if (q_iowr)  new_kind = K_IOWR;
        else if (q_iord)  new_kind = K_IORD;
        else              any_q    = 1'b0;
    end

    state_t      state_q, state_d;
    logic [2:0]  kind_q, kind_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        push;

    // The cycle stays open only while the qualifier of the kind it started as
    // is still true; a different qualifier appearing does not extend it.
    always_comb begin
        case (kind_q)
            K_FETCH: kind_hold = q_fetch;
            K_MRD:   kind_hold = q_mrd;
            K_MWR:   kind_hold = q_mwr;
            K_IORD:  kind_hold = q_iord;
            K_IOWR:  kind_hold = q_iowr;
            K_INTA:  kind_hold = q_inta;
            default: kind_hold = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        addr_d  = addr_q;
        data_d  = data_q;
        push    = 1'b0;
        if (cen) begin
            case (state_q)
                S_IDLE: begin
                    if (trace_en && any_q) begin
                        state_d = S_ACTIVE;
                        kind_d  = new_kind;
                        addr_d  = A;
                        data_d  = sel_data(new_kind, di, dout);
                    end
                end
                S_ACTIVE: begin
                    if (kind_hold) data_d  = sel_data(kind_q, di, dout);
                    else           state_d = S_COMMIT;
                end
                S_COMMIT: begin
                    push = 1'b1;
                    // Start the next cycle on this same edge so back-to-back
                    // bus cycles are not lost.
                    if (trace_en && any_q) begin
                        state_d = S_ACTIVE;
                        kind_d  = new_kind;
                        addr_d  = A;
                        data_d  = sel_data(new_kind, di, dout);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Record fields are only meaningful while state says so; no reset needed.
    always_ff @(posedge clk) begin
        kind_q <= kind_d;
        addr_q <= addr_d;
        data_q <= data_d;
    end

    logic [26:0]   mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          full, pop, push_ok, drop;
    logic          overflow_q;
    logic [CNT_W-1:0] dropped_q;

    assign trace_count = wr_ptr_q - rd_ptr_q;
    assign trace_valid = (wr_ptr_q != rd_ptr_q);
    assign full        = (trace_count == FULL_CNT);
    assign pop         = trace_valid && trace_rdy;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push_ok     = push && (!full || pop);
    assign drop        = push && full && !pop;
    assign trace_data  = trace_valid ? mem_q[rd_ptr_q[AW-1:0]] : 27'd0;
    assign overflow    = overflow_q;
    assign dropped     = dropped_q;

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= {kind_q, addr_q, data_q};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            if (drop) begin
                overflow_q <= 1'b1;
                dropped_q  <= sat_inc(dropped_q);
            end
        end
    end

endmodule

// File: tb/tb_z80_bus_tracer.sv
`timescale 1ns/1ps
module tb_z80_bus_tracer;
    localparam int DEPTH = 16;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic reset_n, cen, trace_en;
    logic m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
    logic [15:0] A;
    logic [7:0] di, dout;
    logic trace_valid;
    logic [26:0] trace_data;
    logic trace_rdy;
    logic [4:0] trace_count;
    logic overflow;
    logic [CNT_W-1:0] dropped;

    always #5 clk = ~clk;

    z80_bus_tracer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .cen(cen), .trace_en(trace_en),
        .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n),
        .wr_n(wr_n), .rfsh_n(rfsh_n), .A(A), .di(di), .dout(dout),
        .trace_valid(trace_valid), .trace_data(trace_data),
        .trace_rdy(trace_rdy), .trace_count(trace_count),
        .overflow(overflow), .dropped(dropped)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: the list of records that should be in the FIFO, in order.
    logic [26:0] exp_q[$];
    logic [26:0] got_q[$];
    logic        m_ovf;
    logic [7:0]  m_drop;

    function automatic void model_push(input logic [26:0] r);
        if (exp_q.size() < DEPTH) exp_q.push_back(r);
        else begin
            m_ovf = 1'b1;
            if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
        end
    endfunction

    // k: 0..5 record kinds, 6 = refresh, anything else = bus idle
    task automatic set_strobes(input int k);
        m1_n = 1; mreq_n = 1; iorq_n = 1; rd_n = 1; wr_n = 1; rfsh_n = 1;
        case (k)
            0: begin m1_n = 0; mreq_n = 0; rd_n = 0; end
            1: begin mreq_n = 0; rd_n = 0; end
            2: begin mreq_n = 0; wr_n = 0; end
            3: begin iorq_n = 0; rd_n = 0; end
            4: begin iorq_n = 0; wr_n = 0; end
            5: begin m1_n = 0; iorq_n = 0; end
            6: begin mreq_n = 0; rfsh_n = 0; end
            default: ;
        endcase
    endtask

    // Holds the strobes for n enabled edges; only the last edge carries the
    // final data, and the address changes after the first edge. Returns on
    // the negedge where the bus goes idle.
    task automatic drive_cycle(input int k, input logic [15:0] a,
                               input logic [7:0] d, input int n, input bit expect_rec);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            set_strobes(k);
            A = (i == 0) ? a : 16'($urandom);
            if (k == 2 || k == 4) begin
                dout = (i == n - 1) ? d : 8'($urandom);
                di   = 8'($urandom);
            end else begin
                di   = (i == n - 1) ? d : 8'($urandom);
                dout = 8'($urandom);
            end
        end
        @(negedge clk);
        set_strobes(-1);
        A = 16'($urandom); di = 8'($urandom); dout = 8'($urandom);
        if (expect_rec) model_push({3'(k), a, d});
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_n(input int n);
        got_q.delete();
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            while (trace_valid !== 1'b1 && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (trace_valid !== 1'b1) return;
            got_q.push_back(trace_data);
            trace_rdy = 1'b1;
            @(negedge clk);
            trace_rdy = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 0; cen = 1; trace_en = 1; trace_rdy = 0;
        set_strobes(-1); A = 0; di = 0; dout = 0;
        exp_q.delete(); m_ovf = 0; m_drop = 0;
        #22;
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", trace_valid); end
        checks++; if (trace_data !== 27'd0) begin errors++; $display("FAIL rst_data got=%h exp=0", trace_data); end
        checks++; if (trace_count !== 5'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", trace_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
        checks++; if (dropped !== 8'd0) begin errors++; $display("FAIL rst_dropped got=%0d exp=0", dropped); end
        @(negedge clk);
        reset_n = 1;
        settle();
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", trace_valid); end
    endtask

    task automatic test_fetch_pair();
        drive_cycle(0, 16'h0000, 8'hCB, 2, 1);
        drive_cycle(0, 16'h0001, 8'hB2, 2, 1);
        @(negedge clk);
        checks++; if (trace_count !== 5'd1) begin errors++; $display("FAIL fetch_lat1 count got=%0d exp=1", trace_count); end
        @(negedge clk);
        checks++; if (trace_count !== 5'd2) begin errors++; $display("FAIL fetch_lat2 count got=%0d exp=2", trace_count); end
        pop_n(exp_q.size());
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL fetch_n got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL fetch_rec[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        exp_q.delete();
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL fetch_empty got=%b exp=0", trace_valid); end
    endtask

    task automatic test_mem_rw_refresh();
        drive_cycle(2, 16'h6FF5, 8'h04, 2, 1);
        drive_cycle(6, 16'h0002, 8'h00, 2, 0);
        drive_cycle(1, 16'h6FF5, 8'h04, 2, 1);
        settle();
        checks++; if (trace_count !== 5'd2) begin errors++; $display("FAIL memrw_count got=%0d exp=2", trace_count); end
        pop_n(exp_q.size());
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL memrw_n got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL memrw_rec[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        exp_q.delete();
    endtask

    task automatic test_io_inta();
        drive_cycle(4, 16'h00FE, 8'h5A, 2, 1);
        drive_cycle(3, 16'h0010, 8'h33, 1, 1);
        drive_cycle(5, 16'h1234, 8'hFF, 2, 1);
        settle();
        checks++; if (trace_count !== 5'd3) begin errors++; $display("FAIL io_count got=%0d exp=3", trace_count); end
        pop_n(exp_q.size());
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL io_n got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL io_rec[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 10; i++) begin
                int k, n, gap;
                k   = $urandom_range(0, 5);
                n   = $urandom_range(1, 3);
                gap = $urandom_range(0, 2);
                drive_cycle(k, 16'($urandom), 8'($urandom), n, 1);
                repeat (gap) @(negedge clk);
            end
            settle();
            checks++; if (int'(trace_count) != exp_q.size()) begin errors++; $display("FAIL rand_count b=%0d got=%0d exp=%0d", b, trace_count, exp_q.size()); end
            pop_n(exp_q.size());
            checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_n b=%0d got=%0d exp=%0d", b, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_rec[%0d] b=%0d got=%h exp=%h", i, b, got_q[i], exp_q[i]); end
            end
            exp_q.delete();
        end
    endtask

    task automatic test_cen_trace_en();
        logic [15:0] a;
        logic [7:0]  d2;
        a  = 16'($urandom);
        d2 = 8'($urandom);
        @(negedge clk);
        set_strobes(1); A = a; di = 8'($urandom);
        @(negedge clk);
        cen = 0;
        repeat (5) begin
            di = 8'($urandom); A = 16'($urandom);
            @(negedge clk);
        end
        di = d2; cen = 1;
        @(negedge clk);
        set_strobes(-1); cen = 0;
        repeat (5) @(negedge clk);
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL cen_frozen valid got=%b exp=0", trace_valid); end
        cen = 1;
        @(negedge clk);
        checks++; if (trace_count !== 5'd0) begin errors++; $display("FAIL cen_commit count got=%0d exp=0", trace_count); end
        @(negedge clk);
        checks++; if (trace_count !== 5'd1) begin errors++; $display("FAIL cen_push count got=%0d exp=1", trace_count); end
        model_push({3'd1, a, d2});
        // Pop path works with the clock enable low.
        cen = 0;
        pop_n(1);
        cen = 1;
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL cen_pop_n got=%0d exp=1", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL cen_rec got=%h exp=%h", got_q[0], exp_q[0]); end
        end
        exp_q.delete();

        trace_en = 0;
        drive_cycle(0, 16'($urandom), 8'($urandom), 2, 0);
        settle();
        trace_en = 1;
        settle();
        checks++; if (trace_count !== 5'd0) begin errors++; $display("FAIL ten_off count got=%0d exp=0", trace_count); end

        // trace_en dropping after the cycle started lets it finish.
        a = 16'($urandom); d2 = 8'($urandom);
        @(negedge clk);
        set_strobes(3); A = a; di = d2;
        @(negedge clk);
        trace_en = 0; A = 16'($urandom);
        @(negedge clk);
        set_strobes(-1);
        settle();
        checks++; if (trace_count !== 5'd1) begin errors++; $display("FAIL ten_active count got=%0d exp=1", trace_count); end
        trace_en = 1;
        model_push({3'd3, a, d2});
        pop_n(1);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL ten_pop_n got=%0d exp=1", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL ten_rec got=%h exp=%h", got_q[0], exp_q[0]); end
        end
        exp_q.delete();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) drive_cycle(1, 16'($urandom), 8'($urandom), 1, 1);
        settle();
        checks++; if (trace_count !== 5'd16) begin errors++; $display("FAIL full_count got=%0d exp=16", trace_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_noovf got=%b exp=0", overflow); end
        for (int i = 0; i < 4; i++) drive_cycle(1, 16'($urandom), 8'($urandom), 1, 1);
        settle();
        checks++; if (int'(trace_count) != exp_q.size()) begin errors++; $display("FAIL ovf_count got=%0d exp=%0d", trace_count, exp_q.size()); end
        checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL ovf_flag got=%b exp=%b", overflow, m_ovf); end
        checks++; if (dropped !== m_drop) begin errors++; $display("FAIL ovf_dropped got=%0d exp=%0d", dropped, m_drop); end

        // Push and pop on the same edge while full.
        begin
            logic [15:0] a;
            logic [7:0]  d;
            a = 16'($urandom); d = 8'($urandom);
            drive_cycle(1, a, d, 1, 0);
            @(negedge clk);
            trace_rdy = 1;
            @(negedge clk);
            trace_rdy = 0;
            void'(exp_q.pop_front());
            model_push({3'd1, a, d});
        end
        checks++; if (int'(trace_count) != exp_q.size()) begin errors++; $display("FAIL pp_count got=%0d exp=%0d", trace_count, exp_q.size()); end
        checks++; if (dropped !== m_drop) begin errors++; $display("FAIL pp_dropped got=%0d exp=%0d", dropped, m_drop); end
        pop_n(exp_q.size());
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_n got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_rec[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        exp_q.delete();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) drive_cycle($urandom_range(0, 5), 16'($urandom), 8'($urandom), 1, 1);
        settle();
        checks++; if (trace_count !== 5'd3) begin errors++; $display("FAIL rm_pre count got=%0d exp=3", trace_count); end
        @(negedge clk);
        set_strobes(2); A = 16'($urandom); dout = 8'($urandom);
        @(negedge clk);
        #2;
        reset_n = 0;
        #1;
        exp_q.delete(); m_ovf = 0; m_drop = 0;
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got=%b exp=0", trace_valid); end
        checks++; if (trace_count !== 5'd0) begin errors++; $display("FAIL rm_count got=%0d exp=0", trace_count); end
        checks++; if (trace_data !== 27'd0) begin errors++; $display("FAIL rm_data got=%h exp=0", trace_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rm_ovf got=%b exp=0", overflow); end
        checks++; if (dropped !== 8'd0) begin errors++; $display("FAIL rm_dropped got=%0d exp=0", dropped); end
        set_strobes(-1);
        @(negedge clk);
        reset_n = 1;
        drive_cycle(4, 16'($urandom), 8'($urandom), 2, 1);
        settle();
        checks++; if (trace_count !== 5'd1) begin errors++; $display("FAIL rm_after count got=%0d exp=1", trace_count); end
        pop_n(exp_q.size());
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rm_n got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rm_rec[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_fetch_pair();
        test_mem_rw_refresh();
        test_io_inta();
        test_random();
        test_cen_trace_en();
        test_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/z80_bus_tracer.md
Name: z80_bus_tracer

Overview:
- Passive monitor on the tv80s CPU bus, downstream of the core, alongside the memory and IO models.
- Classifies each completed bus cycle: opcode fetch, memory read/write, IO read/write, interrupt acknowledge.
- Packs each cycle into one trace record and buffers records in an internal FIFO.
- Testbenches and a host debug port pop records to check bus-level ordering, addresses and data without probing core internals.

Parameters:
- DEPTH, 16, number of trace records held in the FIFO; must be a power of 2, ≥2.
- CNT_W, 8, width of the saturating dropped-record counter.

Ports:
- clk  in  1  CPU clock, same net as the core clock.
- reset_n  in  1  asynchronous active-low reset.
- cen  in  1  clock enable, mirrors the core cen. When 0, bus sampling and the state machine are frozen. The FIFO pop path stays live.
- trace_en  in  1  when 0, no new cycle is started. A cycle already in ACTIVE still completes.
- m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n  in  1 each  CPU bus strobes.
- A  in  16  CPU address bus.
- di  in  8  data into the CPU (read data).
- dout  in  8  data out of the CPU (write data).
- trace_valid  out  1  FIFO not empty.
- trace_data  out  27  head record: {kind[2:0], addr[15:0], data[7:0]}.
- trace_rdy  in  1  pop strobe; the head is consumed on any clk edge where trace_valid & trace_rdy.
- trace_count  out  log2(DEPTH)+1  records currently held.
- overflow  out  1  sticky; set on the first dropped record.
- dropped  out  CNT_W  dropped-record count, saturates at all-ones.

Behaviour:
- Reset values, asynchronous on reset_n low:
  - trace_valid=0, trace_data=0, trace_count=0, overflow=0, dropped=0.
  - State machine returns to IDLE; FIFO pointers clear.
  - A reset asserted mid-cycle discards the partial record.
- Bus-cycle qualifiers, sampled on the rising edge of clk with cen=1:
  - fetch = !m1_n & !mreq_n & !rd_n
  - mrd = m1_n & !mreq_n & !rd_n & rfsh_n
  - mwr = !mreq_n & !wr_n
  - iord = !iorq_n & !rd_n & m1_n
  - iowr = !iorq_n & !wr_n
  - inta = !m1_n & !iorq_n
  - Refresh (!rfsh_n & !mreq_n) is never traced.
- kind encoding: 0=fetch, 1=mrd, 2=mwr, 3=iord, 4=iowr, 5=inta; 6 and 7 are reserved.
- Priority when several qualifiers are true: inta > fetch > mwr > mrd > iowr > iord.
- State machine:
  - IDLE: if trace_en and any qualifier is true, latch kind and A, latch data, go to ACTIVE.
  - ACTIVE: while the latched kind's qualifier stays true, re-latch data every enabled edge. The last sampled value wins; data = di for kinds 0, 1, 3, 5 and dout for kinds 2, 4. The address is not re-latched. When the qualifier goes false, go to COMMIT.
  - COMMIT: push the record, then go to IDLE. If a new qualifier is already true on this same edge, latch it and go straight to ACTIVE, so back-to-back cycles are not lost.
- Latency: a record becomes visible on trace_valid/trace_data two enabled edges after the last edge at which the strobe was sampled low.
- FIFO:
  - Head-of-FIFO output: trace_data is valid whenever trace_valid=1.
  - Pop when empty: ignored.
  - Push when full with no pop on that edge: record dropped, overflow set, dropped incremented (saturating).
  - Push and pop on the same edge while full: both performed, nothing dropped.
  - Push and pop on the same edge while empty: the push is kept and the pop is ignored.
  - Pointers wrap modulo DEPTH; trace_count = wr - rd, computed on the extra-bit pointers.
- overflow and dropped clear only on reset.

Test Plan:
- Fetch pair: bench drives fetch cycles at 0x0000 with di=0xCB, then 0x0001 with di=0xB2 -> records {0,0000,CB} then {0,0001,B2}. After the second record's latency, trace_count=2.
- Memory write then read: mwr A=0x6FF5 dout=0x04, then mrd A=0x6FF5 di=0x04 -> {2,6FF5,04} then {1,6FF5,04}. A refresh cycle driven between them (rfsh_n=0, A=0x0002) produces no record.
- IO and interrupt acknowledge: iowr A=0x00FE dout=0x5A, iord A=0x0010 di=0x33, inta di=0xFF -> {4,00FE,5A}, {3,0010,33}, {5,xxxx,FF} with addr equal to the A latched at cycle start.
- Overflow: DEPTH=16, trace_rdy held 0, 20 mrd cycles -> trace_count=16, overflow=1, dropped=4. Then pop while pushing one record while full -> trace_count stays 16, dropped stays 4.
- cen and trace_en: hold cen=0 for 5 clocks in mid-cycle -> the record appears only after cen returns and the strobe releases. trace_en=0 during a full fetch -> no record.
- Reset mid-cycle: assert reset_n=0 while ACTIVE with 3 records queued -> trace_valid=0 and trace_count=0 immediately, with no clk edge needed. The first cycle after release is traced normally.
